// File: rtl/apb_master_adapter_if.sv
// apb_master_adapter_if: request/response port and APB requester bus for apb_master_adapter
interface apb_master_adapter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_COUNT = DATA_WIDTH < 8 ? 1 : 2 ** ($clog2(DATA_WIDTH) - 3)
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BYTE_COUNT-1:0] req_strb;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  resp_timeout;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [BYTE_COUNT-1:0] pstrb;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, prdata, pready, pslverr,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
           paddr, pwrite, psel, penable, pstrb, pwdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, prdata, pready, pslverr,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
           paddr, pwrite, psel, penable, pstrb, pwdata
  );
endinterface

// File: rtl/apb_master_adapter.sv
// apb_master_adapter: single-outstanding valid/ready request port to APB3/APB4 requester
module apb_master_adapter #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter bit BYTE_EN        = 1'b0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int BYTE_COUNT     = DATA_WIDTH < 8 ? 1 : 2 ** ($clog2(DATA_WIDTH) - 3)
) (
  input logic pclk,
  input logic presetn,
  apb_master_adapter_if.master bus
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [BYTE_COUNT-1:0] pstrb_q, pstrb_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  resp_timeout_q, resp_timeout_d;
  logic                  expire;
  // the last permitted wait cycle is the one where the counter already holds TIMEOUT_CYCLES-1
  assign expire = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    paddr_d        = paddr_q;
    pwrite_d       = pwrite_q;
    pwdata_d       = pwdata_q;
    pstrb_d        = pstrb_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;
    resp_timeout_d = resp_timeout_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d  = SETUP;
        paddr_d  = bus.req_addr;
        pwrite_d = bus.req_write;
        pwdata_d = bus.req_wdata;
        pstrb_d  = bus.req_write ? (BYTE_EN ? bus.req_strb : '1) : '0;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: if (bus.pready) begin
        state_d        = IDLE;
        resp_valid_d   = 1'b1;
        resp_rdata_d   = pwrite_q ? '0 : bus.prdata;
        resp_err_d     = bus.pslverr;
        resp_timeout_d = 1'b0;
      end else if (expire) begin
        state_d        = IDLE;
        resp_valid_d   = 1'b1;
        resp_rdata_d   = '0;
        resp_err_d     = 1'b1;
        resp_timeout_d = 1'b1;
      end else begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      paddr_q        <= '0;
      pwrite_q       <= 1'b0;
      pwdata_q       <= '0;
      pstrb_q        <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      paddr_q        <= paddr_d;
      pwrite_q       <= pwrite_d;
      pwdata_q       <= pwdata_d;
      pstrb_q        <= pstrb_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end
  assign bus.req_ready    = state_q == IDLE;
  assign bus.psel         = state_q != IDLE;
  assign bus.penable      = state_q == ACCESS;
  assign bus.paddr        = paddr_q;
  assign bus.pwrite       = pwrite_q;
  assign bus.pwdata       = pwdata_q;
  assign bus.pstrb        = pstrb_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_timeout = resp_timeout_q;
endmodule

// File: tb/tb_apb_master_adapter.sv
// tb_apb_master_adapter: directed checks of two adapter builds (byte strobes + timeout 4, and all-ones strobes without timeout)
module tb_apb_master_adapter;
  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        rv = 1'b0, rw = 1'b0, prdy = 1'b1, perr = 1'b0;
  logic [11:0] ra = '0;
  logic [31:0] rwd = '0, prd = '0;
  logic [3:0]  rs = '0;
  int          n_cmp = 0, n_err = 0, pulses = 0;
  always #5 pclk = ~pclk;
  apb_master_adapter_if ia ();
  apb_master_adapter_if ib ();
  assign ia.req_valid = rv;  assign ib.req_valid = rv;
  assign ia.req_write = rw;  assign ib.req_write = rw;
  assign ia.req_addr  = ra;  assign ib.req_addr  = ra;
  assign ia.req_wdata = rwd; assign ib.req_wdata = rwd;
  assign ia.req_strb  = rs;  assign ib.req_strb  = rs;
  assign ia.prdata    = prd; assign ib.prdata    = prd;
  assign ia.pready    = prdy; assign ib.pready   = prdy;
  assign ia.pslverr   = perr; assign ib.pslverr  = perr;
  apb_master_adapter #(.BYTE_EN(1'b1), .TIMEOUT_CYCLES(4)) dut_a (.pclk(pclk), .presetn(presetn), .bus(ia));
  apb_master_adapter #(.BYTE_EN(1'b0), .TIMEOUT_CYCLES(0)) dut_b (.pclk(pclk), .presetn(presetn), .bus(ib));
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #1;
    chk("rst_ready", 32'(ia.req_ready), 1);
    chk("rst_psel", 32'(ia.psel), 0);
    chk("rst_penable", 32'(ia.penable), 0);
    chk("rst_resp_valid", 32'(ia.resp_valid), 0);
    chk("rst_paddr", 32'(ia.paddr), 0);
    #12 presetn = 1'b1;
    tick();
    // read, zero wait states
    rv = 1'b1; rw = 1'b0; ra = 12'h010; prd = 32'hDEADBEEF; prdy = 1'b1;
    tick(); rv = 1'b0;
    chk("rd_setup_psel", 32'(ia.psel), 1);
    chk("rd_setup_penable", 32'(ia.penable), 0);
    chk("rd_setup_paddr", 32'(ia.paddr), 32'h010);
    chk("rd_setup_pstrb", 32'(ia.pstrb), 0);
    chk("rd_setup_ready", 32'(ia.req_ready), 0);
    tick();
    chk("rd_access_penable", 32'(ia.penable), 1);
    tick(); prd = 32'h0;
    chk("rd_resp_valid", 32'(ia.resp_valid), 1);
    chk("rd_resp_rdata", ia.resp_rdata, 32'hDEADBEEF);
    chk("rd_resp_err", 32'(ia.resp_err), 0);
    chk("rd_resp_psel", 32'(ia.psel), 0);
    tick();
    chk("rd_resp_pulse", 32'(ia.resp_valid), 0);
    chk("rd_rdata_hold", ia.resp_rdata, 32'hDEADBEEF);
    chk("rd_paddr_hold", 32'(ia.paddr), 32'h010);
    // write with byte strobes
    rv = 1'b1; rw = 1'b1; ra = 12'h024; rwd = 32'h12345678; rs = 4'b0101;
    tick(); rv = 1'b0; rwd = 32'hFFFFFFFF; rs = 4'b0;
    chk("wr_pstrb_byte_en", 32'(ia.pstrb), 32'h5);
    chk("wr_pstrb_all_ones", 32'(ib.pstrb), 32'hF);
    chk("wr_pwrite", 32'(ia.pwrite), 1);
    chk("wr_pwdata_setup", ia.pwdata, 32'h12345678);
    tick();
    chk("wr_pwdata_access", ia.pwdata, 32'h12345678);
    chk("wr_pstrb_access", 32'(ia.pstrb), 32'h5);
    prd = 32'hA5A5A5A5;
    tick();
    chk("wr_resp_valid_a", 32'(ia.resp_valid), 1);
    chk("wr_resp_valid_b", 32'(ib.resp_valid), 1);
    chk("wr_resp_rdata", ia.resp_rdata, 0);
    // read, three wait states, slave error on the ready cycle
    rv = 1'b1; rw = 1'b0; ra = 12'h030; prdy = 1'b0; perr = 1'b0; prd = 32'hCAFE0001;
    tick(); rv = 1'b0; ra = 12'hFFF;
    tick(); tick(); tick();
    chk("ws_penable", 32'(ia.penable), 1);
    chk("ws_paddr", 32'(ia.paddr), 32'h030);
    chk("ws_pwrite", 32'(ia.pwrite), 0);
    tick();
    chk("ws_4th_psel", 32'(ia.psel), 1);
    chk("ws_4th_paddr", 32'(ia.paddr), 32'h030);
    chk("ws_4th_resp_valid", 32'(ia.resp_valid), 0);
    prdy = 1'b1; perr = 1'b1;
    tick(); perr = 1'b0;
    chk("ws_resp_valid", 32'(ia.resp_valid), 1);
    chk("ws_resp_err", 32'(ia.resp_err), 1);
    chk("ws_resp_timeout", 32'(ia.resp_timeout), 0);
    chk("ws_resp_rdata", ia.resp_rdata, 32'hCAFE0001);
    chk("ws_resp_valid_b", 32'(ib.resp_valid), 1);
    // timeout: pready never set for dut_a
    rv = 1'b1; ra = 12'h038; prdy = 1'b0; prd = 32'h11111111;
    tick(); rv = 1'b0;
    tick(); tick(); tick(); tick();
    chk("to_4th_psel", 32'(ia.psel), 1);
    tick();
    chk("to_resp_valid", 32'(ia.resp_valid), 1);
    chk("to_resp_err", 32'(ia.resp_err), 1);
    chk("to_resp_timeout", 32'(ia.resp_timeout), 1);
    chk("to_resp_rdata", ia.resp_rdata, 0);
    chk("to_psel_drop", 32'(ia.psel), 0);
    chk("to_ready", 32'(ia.req_ready), 1);
    chk("to_b_still_waiting", 32'(ib.penable), 1);
    chk("to_b_no_resp", 32'(ib.resp_valid), 0);
    prdy = 1'b1;
    tick();
    chk("to_b_resp_valid", 32'(ib.resp_valid), 1);
    chk("to_b_rdata", ib.resp_rdata, 32'h11111111);
    chk("to_b_timeout", 32'(ib.resp_timeout), 0);
    chk("to_a_one_pulse", 32'(ia.resp_valid), 0);
    // back-to-back with req_valid held high
    rv = 1'b1; rw = 1'b0; ra = 12'h040; prd = 32'h00000040; pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 4) rv = 1'b0;
      pulses += int'(ia.resp_valid);
      if (i == 3) chk("b2b_ready_with_resp", 32'({ia.req_ready, ia.resp_valid}), 32'h3);
      if (i == 4) chk("b2b_second_setup", 32'(ia.psel), 1);
    end
    chk("b2b_pulses", 32'(pulses), 2);
    // asynchronous reset during ACCESS
    rv = 1'b1; ra = 12'h050; prdy = 1'b0;
    tick(); rv = 1'b0;
    tick();
    chk("ar_penable_before", 32'(ia.penable), 1);
    #2 presetn = 1'b0;
    #1;
    chk("ar_psel", 32'(ia.psel), 0);
    chk("ar_penable", 32'(ia.penable), 0);
    chk("ar_resp_valid", 32'(ia.resp_valid), 0);
    chk("ar_ready", 32'(ia.req_ready), 1);
    chk("ar_psel_b", 32'(ib.psel), 0);
    @(negedge pclk); presetn = 1'b1; prdy = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(ia.resp_valid) + int'(ib.resp_valid) + int'(ia.psel);
    end
    chk("ar_no_resp_after", 32'(pulses), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
